// File: rtl/buffer_pkg.sv
// Definitions shared by the CDC FIFO buffer and its write-side loader:
// loader state encoding and the default buffer geometry.
package buffer_pkg;

   localparam int unsigned DEF_BIT_WIDTH = 16;
   localparam int unsigned DEF_ADDR_LEN  = 3;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      FILL = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/buffer_loader_skid.sv
// One-entry holding register between the upstream valid/ready source and the
// buffer write port; accepts a new word in the same cycle the held one is loaded.
module buffer_loader_skid #(
   parameter int unsigned bit_width = 16
) (
   input  logic                 clk_w,
   input  logic                 rst,
   input  logic                 i_en,
   input  logic                 i_flush,
   input  logic                 i_valid,
   input  logic [bit_width-1:0] i_data,
   input  logic                 i_load,
   output logic                 o_ready,
   output logic                 o_hold_v,
   output logic [bit_width-1:0] o_data
);

   logic                 r_hold_v;
   logic [bit_width-1:0] r_data;
   logic                 w_accept;

   assign o_ready  = i_en & (~r_hold_v | i_load);
   assign w_accept = i_valid & o_ready;
   assign o_hold_v = r_hold_v;
   assign o_data   = r_data;

   always_ff @(posedge clk_w) begin
      if (rst) begin
         r_hold_v <= 1'b0;
         r_data   <= '0;
      end else if (i_flush) begin
         // Data is left as-is; only the valid flag matters once dropped.
         r_hold_v <= 1'b0;
      end else if (w_accept) begin
         r_hold_v <= 1'b1;
         r_data   <= i_data;
      end else if (i_load) begin
         r_hold_v <= 1'b0;
      end
   end

endmodule

// File: rtl/buffer_loader.sv
// Write-side burst master for the CDC FIFO buffer (clk_w domain).
// Optional stall counter output enabled by BUFFER_LOADER_STALL_CNT_EN.
module buffer_loader
   import buffer_pkg::*;
#(
   parameter int unsigned bit_width = DEF_BIT_WIDTH,
   parameter int unsigned len_w     = 8
) (
   input  logic                 clk_w,
   input  logic                 rst,
   input  logic                 start,
   input  logic [len_w-1:0]     burst_len,
   input  logic                 abort,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [bit_width-1:0] in_data,
   input  logic                 full,
   output logic                 load,
   output logic [bit_width-1:0] data_out,
   output logic                 busy,
   output logic                 done,
   output logic                 aborted,
`ifdef BUFFER_LOADER_STALL_CNT_EN
   output logic [15:0]          stall_cnt,
`endif
   output logic [len_w-1:0]     words_left
);

   state_t           r_state;
   state_t           w_state_d;
   logic [len_w-1:0] r_acc_left;
   logic [len_w-1:0] r_words_left;
   logic             r_done;
   logic             r_aborted;
   logic             w_hold_v;
   logic             w_en;
   logic             w_accept;
   logic             w_start_ok;
   logic             w_last;

   // acc_left counts words still to pull from upstream; words_left those still to load.
   assign w_en     = (r_state == FILL) && (r_acc_left != '0);
   assign load     = w_hold_v & ~full;
   assign w_accept = in_valid & in_ready;

   buffer_loader_skid #(
      .bit_width(bit_width)
   ) u_skid (
      .clk_w   (clk_w),
      .rst     (rst),
      .i_en    (w_en),
      .i_flush (abort),
      .i_valid (in_valid),
      .i_data  (in_data),
      .i_load  (load),
      .o_ready (in_ready),
      .o_hold_v(w_hold_v),
      .o_data  (data_out)
   );

   always_ff @(posedge clk_w) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_d;
   end

   always_comb begin
      w_state_d  = r_state;
      w_start_ok = 1'b0;
      w_last     = 1'b0;
      if (abort) begin
         w_state_d = IDLE;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  w_start_ok = 1'b1;
                  if (burst_len != '0) w_state_d = FILL;
               end
            end
            FILL: begin
               if (load && (r_words_left == len_w'(1))) begin
                  w_last    = 1'b1;
                  w_state_d = DONE;
               end
            end
            DONE:    w_state_d = IDLE;
            default: w_state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_w) begin
      if (rst) begin
         r_acc_left   <= '0;
         r_words_left <= '0;
         r_done       <= 1'b0;
         r_aborted    <= 1'b0;
      end else if (abort) begin
         r_acc_left   <= '0;
         r_words_left <= '0;
         r_done       <= 1'b0;
         r_aborted    <= 1'b1;
      end else begin
         r_aborted <= 1'b0;
         r_done    <= w_last | (w_start_ok & (burst_len == '0));
         if (w_start_ok) begin
            r_acc_left   <= burst_len;
            r_words_left <= burst_len;
         end else begin
            if (w_accept) r_acc_left   <= r_acc_left - len_w'(1);
            if (load)     r_words_left <= r_words_left - len_w'(1);
         end
      end
   end

   assign busy       = (r_state == FILL);
   assign done       = r_done;
   assign aborted    = r_aborted;
   assign words_left = r_words_left;

`ifdef BUFFER_LOADER_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk_w) begin
      if (rst || w_start_ok) begin
         r_stall_cnt <= '0;
      end else if (busy && w_hold_v && full && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_buffer_loader.sv
// Self-checking bench for buffer_loader: directed vector table plus randomized
// bursts checked against a queue-based handshake model.
module tb_buffer_loader;

   localparam int unsigned BW = 16;
   localparam int unsigned LW = 8;

   logic          clk_w = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [LW-1:0] burst_len = '0;
   logic          abort = 1'b0;
   logic          in_valid = 1'b0;
   logic [BW-1:0] in_data = '0;
   logic          full = 1'b0;
   logic          in_ready;
   logic          load;
   logic [BW-1:0] data_out;
   logic          busy;
   logic          done;
   logic          aborted;
   logic [LW-1:0] words_left;
`ifdef BUFFER_LOADER_STALL_CNT_EN
   logic [15:0]   stall_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk_w = ~clk_w;

   buffer_loader #(
      .bit_width(BW),
      .len_w    (LW)
   ) dut (
      .clk_w     (clk_w),
      .rst       (rst),
      .start     (start),
      .burst_len (burst_len),
      .abort     (abort),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .full      (full),
      .load      (load),
      .data_out  (data_out),
      .busy      (busy),
      .done      (done),
      .aborted   (aborted),
`ifdef BUFFER_LOADER_STALL_CNT_EN
      .stall_cnt (stall_cnt),
`endif
      .words_left(words_left)
   );

   typedef struct {
      logic          rst;
      logic          start;
      logic [LW-1:0] len;
      logic          abort;
      logic          valid;
      logic [BW-1:0] data;
      logic          full;
      logic          rdy;
      logic          ld;
      logic [BW-1:0] dout;
      logic          busy;
      logic          done;
      logic          abrt;
      logic [LW-1:0] wl;
   } vec_t;

   vec_t vecs[$];

   function automatic void mk(input int r, input int s, input int l, input int a, input int v,
                              input int d, input int f, input int er, input int el, input int ed,
                              input int eb, input int edn, input int ea, input int ew);
      vec_t t;
      t.rst = (r != 0);  t.start = (s != 0); t.len = LW'(l);   t.abort = (a != 0);
      t.valid = (v != 0); t.data = BW'(d);   t.full = (f != 0);
      t.rdy = (er != 0);  t.ld = (el != 0);  t.dout = BW'(ed); t.busy = (eb != 0);
      t.done = (edn != 0); t.abrt = (ea != 0); t.wl = LW'(ew);
      vecs.push_back(t);
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk_w);
      rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; full = 1'b0;
      @(negedge clk_w);
      rst = 1'b0;
   endtask

   // One randomized burst; the model tracks accepted-but-unloaded words in a queue.
   task automatic run_burst(input int len);
      logic [BW-1:0] q[$];
      int            acc = 0;
      int            nld = 0;
      int            cyc = 0;
      logic          hold, e_ld, e_rdy;
      @(negedge clk_w);
      start = 1'b1; burst_len = LW'(len); abort = 1'b0; in_valid = 1'b0; full = 1'b0;
      @(negedge clk_w);
      start = 1'b0;
      forever begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_data  = BW'($urandom);
         full     = ($urandom_range(0, 3) == 0);
         #1;
         if (nld == len) begin
            chk($sformatf("rand len%0d done", len),
                32'({in_ready, load, busy, done, aborted, words_left}),
                32'({1'b0, 1'b0, 1'b0, 1'b1, 1'b0, LW'(0)}));
            break;
         end
         hold  = (q.size() != 0);
         e_ld  = hold & ~full;
         e_rdy = (acc < len) & (~hold | e_ld);
         chk($sformatf("rand len%0d ctl", len),
             32'({in_ready, load, busy, done, aborted, words_left}),
             32'({e_rdy, e_ld, 1'b1, 1'b0, 1'b0, LW'(len - nld)}));
         if (e_ld) begin
            chk($sformatf("rand len%0d data", len), 32'(data_out), 32'(q[0]));
            void'(q.pop_front());
            nld++;
         end
         if (in_valid && e_rdy) begin
            q.push_back(in_data);
            acc++;
         end
         cyc++;
         if (cyc > 8 * len + 20) begin
            errors++;
            checks++;
            $display("FAIL rand len%0d timeout: loaded %0d required %0d", len, nld, len);
            break;
         end
         @(negedge clk_w);
      end
      @(negedge clk_w);
      in_valid = 1'b0; full = 1'b0;
      #1;
      chk($sformatf("rand len%0d idle", len),
          32'({in_ready, load, busy, done, aborted, words_left}), 32'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Basic burst of 4; start during FILL and during DONE is ignored.
      mk(1,0,0,0,0,0,0,       0,0,0,0,0,0,0);
      mk(0,1,4,0,1,'hA000,0,  0,0,0,0,0,0,0);
      mk(0,0,0,0,1,'hA000,0,  1,0,0,1,0,0,4);
      mk(0,1,7,0,1,'hA001,0,  1,1,'hA000,1,0,0,4);
      mk(0,0,0,0,1,'hA002,0,  1,1,'hA001,1,0,0,3);
      mk(0,0,0,0,1,'hA003,0,  1,1,'hA002,1,0,0,2);
      mk(0,0,0,0,1,'hA004,0,  0,1,'hA003,1,0,0,1);
      mk(0,1,3,0,0,0,0,       0,0,'hA003,0,1,0,0);
      mk(0,0,0,0,0,0,0,       0,0,'hA003,0,0,0,0);
      // Backpressure: full for 5 cycles after the first accept.
      mk(1,0,0,0,0,0,0,       0,0,0,0,0,0,0);
      mk(0,1,3,0,1,'hB000,0,  0,0,0,0,0,0,0);
      mk(0,0,0,0,1,'hB000,0,  1,0,0,1,0,0,3);
      for (int i = 0; i < 5; i++) mk(0,0,0,0,1,'hB001,1, 0,0,'hB000,1,0,0,3);
      mk(0,0,0,0,1,'hB001,0,  1,1,'hB000,1,0,0,3);
      mk(0,0,0,0,1,'hB002,0,  1,1,'hB001,1,0,0,2);
      mk(0,0,0,0,1,'hB003,0,  0,1,'hB002,1,0,0,1);
      mk(0,0,0,0,0,0,0,       0,0,'hB002,0,1,0,0);
      mk(0,0,0,0,0,0,0,       0,0,'hB002,0,0,0,0);
      // Zero-length burst.
      mk(0,1,0,0,1,'h1234,0,  0,0,'hB002,0,0,0,0);
      mk(0,0,0,0,1,'h1234,0,  0,0,'hB002,0,1,0,0);
      mk(0,0,0,0,0,0,0,       0,0,'hB002,0,0,0,0);
      // Abort after 3 loads.
      mk(1,0,0,0,0,0,0,       0,0,0,0,0,0,0);
      mk(0,1,8,0,1,'hC000,0,  0,0,0,0,0,0,0);
      mk(0,0,0,0,1,'hC000,0,  1,0,0,1,0,0,8);
      mk(0,0,0,0,1,'hC001,0,  1,1,'hC000,1,0,0,8);
      mk(0,0,0,0,1,'hC002,0,  1,1,'hC001,1,0,0,7);
      mk(0,0,0,0,1,'hC003,0,  1,1,'hC002,1,0,0,6);
      mk(0,0,0,1,1,'hC004,1,  0,0,'hC003,1,0,0,5);
      mk(0,0,0,0,1,'hC005,0,  0,0,'hC003,0,0,1,0);
      mk(0,0,0,0,1,'hC006,0,  0,0,'hC003,0,0,0,0);
      // Upstream gaps: in_valid alternating.
      mk(1,0,0,0,0,0,0,       0,0,0,0,0,0,0);
      mk(0,1,5,0,1,'hD000,0,  0,0,0,0,0,0,0);
      mk(0,0,0,0,1,'hD000,0,  1,0,0,1,0,0,5);
      mk(0,0,0,0,0,'hDEAD,0,  1,1,'hD000,1,0,0,5);
      mk(0,0,0,0,1,'hD001,0,  1,0,'hD000,1,0,0,4);
      mk(0,0,0,0,0,'hDEAD,0,  1,1,'hD001,1,0,0,4);
      mk(0,0,0,0,1,'hD002,0,  1,0,'hD001,1,0,0,3);
      mk(0,0,0,0,0,'hDEAD,0,  1,1,'hD002,1,0,0,3);
      mk(0,0,0,0,1,'hD003,0,  1,0,'hD002,1,0,0,2);
      mk(0,0,0,0,0,'hDEAD,0,  1,1,'hD003,1,0,0,2);
      mk(0,0,0,0,1,'hD004,0,  1,0,'hD003,1,0,0,1);
      mk(0,0,0,0,0,'hDEAD,0,  0,1,'hD004,1,0,0,1);
      mk(0,0,0,0,1,'hD005,0,  0,0,'hD004,0,1,0,0);
      mk(0,0,0,0,0,0,0,       0,0,'hD004,0,0,0,0);
      // Reset mid-burst with a held word, then a clean burst of 2.
      mk(0,1,4,0,1,'hE0F0,0,  0,0,'hD004,0,0,0,0);
      mk(0,0,0,0,1,'hE0F0,0,  1,0,'hD004,1,0,0,4);
      mk(0,0,0,0,1,'hE0F1,1,  0,0,'hE0F0,1,0,0,4);
      mk(1,0,0,0,1,'hE0F1,1,  0,0,0,0,0,0,0);
      mk(0,0,0,0,1,'hE0F1,0,  0,0,0,0,0,0,0);
      mk(0,1,2,0,1,'hE000,0,  0,0,0,0,0,0,0);
      mk(0,0,0,0,1,'hE000,0,  1,0,0,1,0,0,2);
      mk(0,0,0,0,1,'hE001,0,  1,1,'hE000,1,0,0,2);
      mk(0,0,0,0,1,'hE002,0,  0,1,'hE001,1,0,0,1);
      mk(0,0,0,0,0,0,0,       0,0,'hE001,0,1,0,0);
      mk(0,0,0,0,0,0,0,       0,0,'hE001,0,0,0,0);
      // Abort coinciding with the final load: word written, aborted wins over done.
      mk(1,0,0,0,0,0,0,       0,0,0,0,0,0,0);
      mk(0,1,1,0,1,'hF000,0,  0,0,0,0,0,0,0);
      mk(0,0,0,0,1,'hF000,0,  1,0,0,1,0,0,1);
      mk(0,0,0,1,0,0,0,       0,1,'hF000,1,0,0,1);
      mk(0,0,0,0,0,0,0,       0,0,'hF000,0,0,1,0);
      mk(0,0,0,0,0,0,0,       0,0,'hF000,0,0,0,0);

      foreach (vecs[i]) begin
         @(negedge clk_w);
         rst = vecs[i].rst;     start = vecs[i].start; burst_len = vecs[i].len;
         abort = vecs[i].abort; in_valid = vecs[i].valid;
         in_data = vecs[i].data; full = vecs[i].full;
         #1;
         if (!vecs[i].rst) begin
            chk($sformatf("vec%0d", i),
                32'({in_ready, load, data_out, busy, done, aborted, words_left}),
                32'({vecs[i].rdy, vecs[i].ld, vecs[i].dout, vecs[i].busy, vecs[i].done,
                     vecs[i].abrt, vecs[i].wl}));
         end
      end

      do_reset();
      run_burst(255);
      run_burst(0);
      run_burst(1);
      for (int i = 0; i < 6; i++) run_burst(int'($urandom_range(1, 40)));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
